// File: rtl/viterbi_if.sv
// Decode request / result bundle between a lane driver and one viterbi_decoder.
interface viterbi_if #(
  parameter int unsigned MSG_W = 8,
  parameter int unsigned PM_W  = 5
);
  localparam int unsigned CODE_W = 2 * MSG_W;

  logic              start;
  logic [CODE_W-1:0] code_in;
  logic [MSG_W-1:0]  m_text_out;
  logic [PM_W-1:0]   metric;
  logic              busy;
  logic              done;

  // Requester side: issues codewords, observes results.
  modport master (
    output start,
    output code_in,
    input  m_text_out,
    input  metric,
    input  busy,
    input  done
  );

  // Decoder side.
  modport slave (
    input  start,
    input  code_in,
    output m_text_out,
    output metric,
    output busy,
    output done
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) code.
// One ACS trellis step per cycle, then a serial traceback, one bit per cycle.
module viterbi_decoder #(
  parameter int unsigned MSG_W  = 8,
  parameter int unsigned CODE_W = 2 * MSG_W,
  parameter int unsigned PM_W   = 5
) (
  input  logic     clk,
  input  logic     reset,
  viterbi_if.slave bus
);
  localparam int unsigned NS    = 4;
  localparam int unsigned CNT_W = $clog2(MSG_W);
  localparam int unsigned IDX_W = $clog2(CODE_W);

  localparam logic [PM_W-1:0]  PM_MAX    = {PM_W{1'b1}};
  localparam logic [PM_W-1:0]  PM_INIT   = PM_W'(2 * MSG_W + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(MSG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACS   = 2'd1,
    S_TRACE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [PM_W-1:0]   pm_q [NS];
  logic [PM_W-1:0]   pm_d [NS];
  logic [MSG_W-1:0]  dec_q [NS];
  logic [MSG_W-1:0]  dec_d [NS];
  logic [CNT_W-1:0]  step_q, step_d;
  logic [1:0]        tr_state_q, tr_state_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [PM_W-1:0]   metric_pend_q, metric_pend_d;
  logic [MSG_W-1:0]  m_text_q, m_text_d;
  logic [PM_W-1:0]   metric_q, metric_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        rx_pair;
  logic [PM_W-1:0]   acs_pm [NS];
  logic [NS-1:0]     acs_dec;
  logic [1:0]        best_s;
  logic [PM_W-1:0]   best_pm;
  logic [1:0]        cur_s;
  logic [CNT_W-1:0]  tr_t;

  // Hamming distance between a received pair and the pair emitted on a branch.
  // pred = {m_{t-1}, m_{t-2}}, b = m_t; pair bit0 = b^m1^m2, bit1 = b^m2.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                               input logic [1:0] pred,
                                               input logic       b);
    logic [1:0] exp_pair;
    logic [1:0] diff;
    exp_pair = {b ^ pred[0], b ^ pred[1] ^ pred[0]};
    diff     = rx ^ exp_pair;
    return 2'(diff[0]) + 2'(diff[1]);
  endfunction

  // Path metric plus branch metric, clamped at the all-ones value.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                              input logic [1:0]      bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + (PM_W + 1)'(bm);
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  // Received symbol pair for the current trellis step.
  assign rx_pair = code_q[IDX_W'({step_q, 1'b0}) +: 2];

  // Add-compare-select per next state s={b,x}; ties keep the dropped-bit-0 predecessor.
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [1:0] S  = 2'(g);
    localparam logic [1:0] P0 = {S[0], 1'b0};
    localparam logic [1:0] P1 = {S[0], 1'b1};

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0      = sat_add(pm_q[P0], branch_metric(rx_pair, P0, S[1]));
    assign cand1      = sat_add(pm_q[P1], branch_metric(rx_pair, P1, S[1]));
    assign acs_dec[g] = (cand1 < cand0);
    assign acs_pm[g]  = (cand1 < cand0) ? cand1 : cand0;
  end

  // Lowest-index state holding the minimum path metric.
  always_comb begin
    best_s  = 2'd0;
    best_pm = pm_q[0];
    for (int s = 1; s < NS; s++) begin
      if (pm_q[s] < best_pm) begin
        best_pm = pm_q[s];
        best_s  = 2'(s);
      end
    end
  end

  // Traceback position: first cycle starts from the best final state.
  always_comb begin
    cur_s = (step_q == '0) ? best_s : tr_state_q;
    tr_t  = STEP_LAST - step_q;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ACS;
      S_ACS:   if (step_q == STEP_LAST) state_d = S_TRACE;
      S_TRACE: if (step_q == STEP_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output and datapath next-values.
  always_comb begin
    code_d        = code_q;
    pm_d          = pm_q;
    dec_d         = dec_q;
    step_d        = step_q;
    tr_state_d    = tr_state_q;
    msg_d         = msg_q;
    metric_pend_d = metric_pend_q;
    m_text_d      = m_text_q;
    metric_d      = metric_q;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          code_d  = bus.code_in;
          pm_d[0] = '0;
          for (int s = 1; s < NS; s++) pm_d[s] = PM_INIT;
          step_d  = '0;
          msg_d   = '0;
        end
      end
      S_ACS: begin
        for (int s = 0; s < NS; s++) begin
          pm_d[s]         = acs_pm[s];
          dec_d[s][step_q] = acs_dec[s];
        end
        step_d = (step_q == STEP_LAST) ? '0 : step_q + CNT_W'(1);
      end
      S_TRACE: begin
        msg_d[tr_t] = cur_s[1];
        tr_state_d  = {cur_s[0], dec_q[cur_s][tr_t]};
        if (step_q == '0) metric_pend_d = best_pm;
        step_d = (step_q == STEP_LAST) ? '0 : step_q + CNT_W'(1);
        if (step_q == STEP_LAST) begin
          m_text_d = msg_d;
          metric_d = metric_pend_d;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears metrics and survivors too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q        <= '0;
      for (int s = 0; s < NS; s++) begin
        pm_q[s]  <= '0;
        dec_q[s] <= '0;
      end
      step_q        <= '0;
      tr_state_q    <= '0;
      msg_q         <= '0;
      metric_pend_q <= '0;
      m_text_q      <= '0;
      metric_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      code_q        <= code_d;
      pm_q          <= pm_d;
      dec_q         <= dec_d;
      step_q        <= step_d;
      tr_state_q    <= tr_state_d;
      msg_q         <= msg_d;
      metric_pend_q <= metric_pend_d;
      m_text_q      <= m_text_d;
      metric_q      <= metric_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.m_text_out = m_text_q;
  assign bus.metric     = metric_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: driver pushes expectations, monitor checks on done.
module tb_viterbi_decoder;
  localparam int unsigned MSG_W = 8;
  localparam int unsigned PM_W  = 5;

  typedef struct {
    logic [7:0] msg;
    logic [4:0] metric;
    logic       chk_msg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  viterbi_if #(.MSG_W(MSG_W), .PM_W(PM_W)) bus ();

  viterbi_decoder #(.MSG_W(MSG_W), .CODE_W(2 * MSG_W), .PM_W(PM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_done   = 0;
  int         n_issued = 0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_m    = '0;
  logic [4:0] prev_met  = '0;

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  // Reference encoder straight from the code equations.
  function automatic logic [15:0] encode(input logic [7:0] m);
    logic [15:0] c;
    logic        m1;
    logic        m2;
    c  = '0;
    m1 = 1'b0;
    m2 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      c[2*t]   = m[t] ^ m1 ^ m2;
      c[2*t+1] = m[t] ^ m2;
      m2 = m1;
      m1 = m[t];
    end
    return c;
  endfunction

  // Maximum-likelihood metric: minimum Hamming distance over all messages.
  function automatic int min_dist(input logic [15:0] code);
    int best;
    int d;
    best = 99;
    for (int m = 0; m < 256; m++) begin
      d = $countones(encode(8'(m)) ^ code);
      if (d < best) best = d;
    end
    return best;
  endfunction

  // Monitor: pops expectations on done, checks pulse width and output hold.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (bus.done) begin
        exp_t e;
        n_done++;
        chk("done_single_cycle", int'(prev_done), 0);
        chk("done_with_pending", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.chk_msg) chk("m_text_out", int'(bus.m_text_out), int'(e.msg));
          chk("metric", int'(bus.metric), int'(e.metric));
        end
      end else begin
        chk("m_text_hold", int'(bus.m_text_out), int'(prev_m));
        chk("metric_hold", int'(bus.metric), int'(prev_met));
      end
    end
    prev_done = bus.done;
    prev_m    = bus.m_text_out;
    prev_met  = bus.metric;
  end

  // Issue one decode; optionally pulse a stray start or reset mid-decode.
  task automatic run(input logic [15:0] code, input logic [7:0] emsg, input logic chk_msg,
                     input int inj_at, input logic [15:0] inj_code, input int rst_at);
    exp_t e;
    int   lat;
    int   bcnt;
    int   done_before;
    e.msg       = emsg;
    e.metric    = 5'(min_dist(code));
    e.chk_msg   = chk_msg;
    done_before = n_done;
    @(negedge clk);
    bus.code_in = code;
    bus.start   = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.code_in = 16'($urandom);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      if (lat == inj_at) begin
        bus.start   = 1'b1;
        bus.code_in = inj_code;
      end
      if (lat == rst_at) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rst_m_text", int'(bus.m_text_out), 0);
        chk("rst_metric", int'(bus.metric), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        e = sb_q.pop_back();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (24) @(posedge clk);
        #2;
        chk("no_done_after_rst", n_done, done_before);
        return;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.busy) bcnt++;
    end
    n_issued++;
    chk("latency", lat, 16);
    chk("busy_cycles", bcnt, 17);
    @(posedge clk);
    #1;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    logic [7:0]  m;
    logic [15:0] c;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.code_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_text", int'(bus.m_text_out), 0);
    chk("reset_metric", int'(bus.metric), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;

    run(16'h0000, 8'h00, 1'b1, -1, 16'h0, -1);
    run(16'h0037, 8'h01, 1'b1, -1, 16'h0, -1);
    run(16'h0027, 8'h01, 1'b1, -1, 16'h0, -1);

    for (int i = 0; i < 10; i++) begin
      m = 8'($urandom);
      run(encode(m), m, 1'b1, -1, 16'h0, -1);
      c = encode(m) ^ (16'h0001 << $urandom_range(0, 9));
      run(c, m, 1'b1, -1, 16'h0, -1);
    end

    for (int i = 0; i < 8; i++) begin
      c = 16'($urandom);
      run(c, 8'h00, 1'b0, -1, 16'h0, -1);
    end

    // Stray start 5 cycles into a decode must be ignored.
    m = 8'($urandom);
    run(encode(m), m, 1'b1, 5, ~encode(m), -1);

    // Leave a nonzero result on the outputs, then reset mid-decode.
    run(16'h0027, 8'h01, 1'b1, -1, 16'h0, -1);
    run(encode(8'hA5), 8'hA5, 1'b1, -1, 16'h0, 9);

    // Normal decode after the interrupted one.
    m = 8'($urandom);
    run(encode(m), m, 1'b1, -1, 16'h0, -1);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_count", n_done, n_issued);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
